// File: rtl/memory_utils.sv
// Shared PDP-8 types and constants: machine word, OPR sequencer states, OPR bit positions.
package memory_utils;

  typedef logic [11:0] word;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } opr_state_t;

  localparam logic [2:0] OPR_OPCODE = 3'b111;

  // Bit 8 selects group 2/3 over group 1; bit 0 then selects group 3 over group 2.
  localparam int OPR_BIT_GRP = 8;
  localparam int OPR_BIT_G3  = 0;
  localparam int OPR_BIT_CLA = 7;

  localparam int G1_BIT_CLL = 6;
  localparam int G1_BIT_CMA = 5;
  localparam int G1_BIT_CML = 4;
  localparam int G1_BIT_RAR = 3;
  localparam int G1_BIT_RAL = 2;
  localparam int G1_BIT_BSW = 1;
  localparam int G1_BIT_IAC = 0;

  localparam int G2_BIT_SMA = 6;
  localparam int G2_BIT_SZA = 5;
  localparam int G2_BIT_SNL = 4;
  localparam int G2_BIT_REV = 3;
  localparam int OPR_BIT_OSR = 2;
  localparam int OPR_BIT_HLT = 1;

  localparam int OPR_BIT_MQA = 6;
  localparam int OPR_BIT_MQL = 4;

endpackage

// File: rtl/opr_execute_unit_if.sv
// Request/result bundle between the main control FSM (master) and the OPR execute unit (slave).
interface opr_execute_unit_if;
  import memory_utils::*;

  // start is a request pulse; it is honoured only while the unit is idle (busy low),
  // there is no back-pressure and no queuing; results are valid in the done cycle.
  logic       start;
  logic [11:0] instr;
  word        ac_in;
  logic       l_in;
  word        pc_in;
  word        sr_in;

  word        ac_out;
  logic       l_out;
  word        pc_out;
  word        mq_out;
  logic       busy;
  logic       done;
  logic       halt;
  logic       error;
  opr_state_t state;

  modport master (
    output start, instr, ac_in, l_in, pc_in, sr_in,
    input  ac_out, l_out, pc_out, mq_out, busy, done, halt, error, state
  );

  modport slave (
    input  start, instr, ac_in, l_in, pc_in, sr_in,
    output ac_out, l_out, pc_out, mq_out, busy, done, halt, error, state
  );

endinterface

// File: rtl/micro_instruction_decoder.sv
// Combinational OPR micro-op decoder: full group 1 result, group 2 skip and CLA, group flags.
module micro_instruction_decoder
  import memory_utils::*;
(
  input  word  i_reg,
  input  word  ac_reg,
  input  logic l_reg,
  output word  ac_micro,
  output logic l_micro,
  output logic skip,
  output logic micro_g1,
  output logic micro_g2,
  output logic micro_g3
);

  logic        is_opr;
  logic [12:0] la;
  logic        cond;

  assign is_opr   = (i_reg[11:9] == OPR_OPCODE);
  assign micro_g1 = is_opr & ~i_reg[OPR_BIT_GRP];
  assign micro_g2 = is_opr &  i_reg[OPR_BIT_GRP] & ~i_reg[OPR_BIT_G3];
  assign micro_g3 = is_opr &  i_reg[OPR_BIT_GRP] &  i_reg[OPR_BIT_G3];

  always_comb begin
    ac_micro = ac_reg;
    l_micro  = l_reg;
    skip     = 1'b0;
    la       = '0;
    cond     = 1'b0;
    if (micro_g1) begin
      // Group 1 sequence: clear, complement, increment (carry toggles L), rotate.
      la = {l_reg, ac_reg};
      if (i_reg[OPR_BIT_CLA]) la[11:0] = '0;
      if (i_reg[G1_BIT_CLL])  la[12]   = 1'b0;
      if (i_reg[G1_BIT_CMA])  la[11:0] = ~la[11:0];
      if (i_reg[G1_BIT_CML])  la[12]   = ~la[12];
      if (i_reg[G1_BIT_IAC])  la = {la[12] ^ (&la[11:0]), la[11:0] + 12'd1};
      case ({i_reg[G1_BIT_RAR], i_reg[G1_BIT_RAL], i_reg[G1_BIT_BSW]})
        3'b100:  la = {la[0], la[12:1]};
        3'b101:  la = {la[1:0], la[12:2]};
        3'b010:  la = {la[11:0], la[12]};
        3'b011:  la = {la[10:0], la[12:11]};
        3'b001:  la = {la[12], la[5:0], la[11:6]};
        default: la = la;
      endcase
      {l_micro, ac_micro} = la;
    end else if (micro_g2) begin
      // Skip conditions look at AC before the group 2 CLA takes effect.
      cond = (i_reg[G2_BIT_SMA] & ac_reg[11]) |
             (i_reg[G2_BIT_SZA] & (ac_reg == '0)) |
             (i_reg[G2_BIT_SNL] & l_reg);
      skip = cond ^ i_reg[G2_BIT_REV];
      if (i_reg[OPR_BIT_CLA]) ac_micro = '0;
    end
  end

endmodule

// File: rtl/opr_execute_unit.sv
// Multi-cycle OPR (opcode 7) sequencer: latch, decode, commit, done/error pulse.
// Optional MQ register and group 3 MQA/MQL/CLA support under `OPR_GROUP3_EN.
module opr_execute_unit
  import memory_utils::*;
#(
  parameter int  WORD_W   = 12,
  parameter word MQ_RESET = 12'o0000
)(
  input logic              clk,
  input logic              reset,
  opr_execute_unit_if.slave bus
);

  opr_state_t state;

  word  instr_q, ac_q, pc_q;
  logic l_q;

  word  ac_res;
  logic l_res, skip_q, g1_q, g2_q, g3_q;

  word  dec_ac;
  logic dec_l, dec_skip, dec_g1, dec_g2, dec_g3;

  word  ac_r, pc_r;
  logic l_r, busy_r, done_r, halt_r, error_r;

  micro_instruction_decoder u_decoder (
    .i_reg    (instr_q),
    .ac_reg   (ac_q),
    .l_reg    (l_q),
    .ac_micro (dec_ac),
    .l_micro  (dec_l),
    .skip     (dec_skip),
    .micro_g1 (dec_g1),
    .micro_g2 (dec_g2),
    .micro_g3 (dec_g3)
  );

`ifdef OPR_GROUP3_EN
  word mq_r;
  word g3_acc;
  assign g3_acc = instr_q[OPR_BIT_CLA] ? '0 : ac_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      instr_q <= '0;
      ac_q    <= '0;
      pc_q    <= '0;
      l_q     <= 1'b0;
      ac_res  <= '0;
      l_res   <= 1'b0;
      skip_q  <= 1'b0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      g3_q    <= 1'b0;
      ac_r    <= '0;
      pc_r    <= '0;
      l_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      halt_r  <= 1'b0;
      error_r <= 1'b0;
`ifdef OPR_GROUP3_EN
      mq_r    <= MQ_RESET;
`endif
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            instr_q <= bus.instr;
            ac_q    <= bus.ac_in;
            l_q     <= bus.l_in;
            pc_q    <= bus.pc_in;
            busy_r  <= 1'b1;
            if (bus.instr[11:9] != OPR_OPCODE) begin
              error_r <= 1'b1;
              state   <= ST_ERR;
            end else begin
              state   <= ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          ac_res <= dec_ac;
          l_res  <= dec_l;
          skip_q <= dec_skip;
          g1_q   <= dec_g1;
          g2_q   <= dec_g2;
          g3_q   <= dec_g3;
          state  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // All architectural outputs change together on this edge only.
          if (g1_q) begin
            ac_r <= ac_res;
            l_r  <= l_res;
            pc_r <= pc_q;
          end else if (g2_q) begin
            ac_r <= instr_q[OPR_BIT_OSR] ? (ac_res | bus.sr_in) : ac_res;
            l_r  <= l_q;
            pc_r <= skip_q ? pc_q + WORD_W'(1) : pc_q;
            if (instr_q[OPR_BIT_HLT]) halt_r <= 1'b1;
          end else if (g3_q) begin
            l_r  <= l_q;
            pc_r <= pc_q;
`ifdef OPR_GROUP3_EN
            case ({instr_q[OPR_BIT_MQA], instr_q[OPR_BIT_MQL]})
              2'b11: begin
                ac_r <= mq_r;
                mq_r <= g3_acc;
              end
              2'b10: ac_r <= g3_acc | mq_r;
              2'b01: begin
                ac_r <= '0;
                mq_r <= g3_acc;
              end
              default: ac_r <= g3_acc;
            endcase
`else
            ac_r <= ac_q;
`endif
          end
          done_r <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_ERR: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ac_out = ac_r;
  assign bus.l_out  = l_r;
  assign bus.pc_out = pc_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.halt   = halt_r;
  assign bus.error  = error_r;
  assign bus.state  = state;
`ifdef OPR_GROUP3_EN
  assign bus.mq_out = mq_r;
`else
  assign bus.mq_out = MQ_RESET;
`endif

endmodule

// File: tb/tb_opr_execute_unit.sv
// Directed bench for opr_execute_unit: latency, results, skip/wrap, OSR/HLT, MQ ops, error, reset.
module tb_opr_execute_unit;
  import memory_utils::*;

`ifdef OPR_GROUP3_EN
  localparam bit G3 = 1'b1;
`else
  localparam bit G3 = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  opr_execute_unit_if bus();

  opr_execute_unit #(.WORD_W(12), .MQ_RESET(12'o0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of cycle N+4.
  task automatic do_op(input string tag, input logic [11:0] instr, input word ac, input logic l,
                       input word pc, input word sr, input word e_ac, input logic e_l,
                       input word e_pc, input word e_mq, input bit hold);
    logic [36:0] e;
    int lat;
    exp_q.push_back({e_ac, e_l, e_pc, e_mq});
    bus.start = 1'b1;
    bus.instr = instr;
    bus.ac_in = ac;
    bus.l_in  = l;
    bus.pc_in = pc;
    bus.sr_in = sr;
    @(negedge clk);
    if (hold) bus.instr = 12'o7001;
    else bus.start = 1'b0;
    bus.ac_in = ~ac;
    bus.l_in  = ~l;
    bus.pc_in = ~pc;
    check({tag, "/busy"}, 32'(bus.busy), 32'd1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd3);
    e = exp_q.pop_front();
    check({tag, "/ac"}, 32'(bus.ac_out), 32'(e[36:25]));
    check({tag, "/l"},  32'(bus.l_out),  32'(e[24]));
    check({tag, "/pc"}, 32'(bus.pc_out), 32'(e[23:12]));
    check({tag, "/mq"}, 32'(bus.mq_out), 32'(e[11:0]));
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "/idle"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic [11:0] instr, input word e_ac,
                        input logic e_l, input word e_pc);
    bus.start = 1'b1;
    bus.instr = instr;
    bus.ac_in = 12'o5555;
    bus.l_in  = ~e_l;
    bus.pc_in = 12'o2222;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "/error_n1"}, {30'd0, bus.error, bus.busy}, 32'd3);
    @(negedge clk);
    check({tag, "/error_n2"}, {29'd0, bus.error, bus.done, bus.busy}, 32'd0);
    check({tag, "/ac_kept"}, 32'(bus.ac_out), 32'(e_ac));
    check({tag, "/l_kept"},  32'(bus.l_out),  32'(e_l));
    check({tag, "/pc_kept"}, 32'(bus.pc_out), 32'(e_pc));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/ac"}, 32'(bus.ac_out), 32'd0);
    check({tag, "/l"},  32'(bus.l_out),  32'd0);
    check({tag, "/pc"}, 32'(bus.pc_out), 32'd0);
    check({tag, "/mq"}, 32'(bus.mq_out), 32'd0);
    check({tag, "/flags"}, {28'd0, bus.busy, bus.done, bus.halt, bus.error}, 32'd0);
    check({tag, "/state"}, 32'(bus.state), 32'(ST_IDLE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held together with a start request: reset must win
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.instr = 12'o7040;
    bus.ac_in = 12'o0000;
    bus.l_in  = 1'b0;
    bus.pc_in = 12'o0100;
    bus.sr_in = 12'o0000;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("post_reset/busy", 32'(bus.busy), 32'd0);

    do_op("cma",      12'o7040, 12'o0000, 1'b0, 12'o0100, 12'o0000, 12'o7777, 1'b0, 12'o0100, 12'o0000, 1'b0);
    do_op("sza_skip", 12'o7440, 12'o0000, 1'b0, 12'o0200, 12'o0000, 12'o0000, 1'b0, 12'o0201, 12'o0000, 1'b0);
    do_op("sza_no",   12'o7440, 12'o0005, 1'b0, 12'o0200, 12'o0000, 12'o0005, 1'b0, 12'o0200, 12'o0000, 1'b1);
    do_op("skp_wrap", 12'o7410, 12'o0000, 1'b1, 12'o7777, 12'o0000, 12'o0000, 1'b1, 12'o0000, 12'o0000, 1'b0);
    do_op("osr",      12'o7404, 12'o0012, 1'b0, 12'o0400, 12'o0101, 12'o0113, 1'b0, 12'o0400, 12'o0000, 1'b0);
    do_op("iac_carry",12'o7001, 12'o7777, 1'b0, 12'o0500, 12'o0000, 12'o0000, 1'b1, 12'o0500, 12'o0000, 1'b0);
    do_op("ral",      12'o7004, 12'o4000, 1'b0, 12'o0600, 12'o0000, 12'o0000, 1'b1, 12'o0600, 12'o0000, 1'b0);
    do_op("mql",      12'o7421, 12'o4321, 1'b0, 12'o0700, 12'o0000,
          G3 ? 12'o0000 : 12'o4321, 1'b0, 12'o0700, G3 ? 12'o4321 : 12'o0000, 1'b0);
    do_op("swp",      12'o7521, 12'o1234, 1'b1, 12'o1000, 12'o0000,
          G3 ? 12'o4321 : 12'o1234, 1'b1, 12'o1000, G3 ? 12'o1234 : 12'o0000, 1'b0);
    do_op("cla_mqa",  12'o7701, 12'o0055, 1'b0, 12'o1100, 12'o0000,
          G3 ? 12'o1234 : 12'o0055, 1'b0, 12'o1100, G3 ? 12'o1234 : 12'o0000, 1'b0);
    check("halt_before", 32'(bus.halt), 32'd0);
    do_op("hlt",      12'o7402, 12'o0006, 1'b1, 12'o0300, 12'o0000,
          12'o0006, 1'b1, 12'o0300, G3 ? 12'o1234 : 12'o0000, 1'b0);
    check("halt_set", 32'(bus.halt), 32'd1);
    do_op("cma2",     12'o7040, 12'o0000, 1'b0, 12'o0310, 12'o0000,
          12'o7777, 1'b0, 12'o0310, G3 ? 12'o1234 : 12'o0000, 1'b0);
    check("halt_sticky", 32'(bus.halt), 32'd1);

    do_err("bad_op", 12'o1234, 12'o7777, 1'b0, 12'o0310);

    // reset lands in COMMIT of a CMA: nothing of it may appear
    bus.start = 1'b1;
    bus.instr = 12'o7040;
    bus.ac_in = 12'o0000;
    bus.l_in  = 1'b0;
    bus.pc_in = 12'o0100;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid/state_commit", 32'(bus.state), 32'(ST_COMMIT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid_reset");
    @(negedge clk);
    check("mid_reset/no_done", {30'd0, bus.done, bus.busy}, 32'd0);

    do_op("after_rst",12'o7040, 12'o0000, 1'b0, 12'o0100, 12'o0000, 12'o7777, 1'b0, 12'o0100, 12'o0000, 1'b0);
    check("halt_cleared", 32'(bus.halt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
